// File: rtl/lpm_mac_ctrl_pkg.sv
// rtl/lpm_mac_ctrl_pkg.sv - shared constants and state encoding for the MAC sequencer
package lpm_mac_ctrl_pkg;

  // Default widths: operand, multiplier product, accumulator, burst counter
  localparam int N_DEF    = 8;
  localparam int PW_DEF   = 20;
  localparam int ACCW_DEF = 28;
  localparam int CNTW_DEF = 8;

  // State register width
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lpm_acc_unit.sv
// rtl/lpm_acc_unit.sv - ACCW-wide accumulator with clear, add-enable and sticky carry-out
module lpm_acc_unit
  import lpm_mac_ctrl_pkg::*;
#(
  parameter int PW   = PW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clr,
  input  logic            i_add_en,
  input  logic [PW-1:0]   i_addend,
  output logic [ACCW-1:0] o_acc,
  output logic            o_ovf
);

  logic [ACCW-1:0] r_acc;
  logic            r_ovf;
  logic [ACCW:0]   w_ext;
  logic [ACCW:0]   w_sum;

  // Zero-extend the product one bit past the accumulator so the top bit is the carry
  assign w_ext = (ACCW+1)'(i_addend);
  assign w_sum = {1'b0, r_acc} + w_ext;

  // Accumulate modulo 2^ACCW; any carry-out latches ovf until the next clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_add_en) begin
      r_acc <= w_sum[ACCW-1:0];
      if (w_sum[ACCW]) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/lpm_mac_ctrl.sv
// rtl/lpm_mac_ctrl.sv - burst sequencer and accumulator around the low-power 8x8 multiplier
module lpm_mac_ctrl
  import lpm_mac_ctrl_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int PW   = PW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [CNTW-1:0] i_len,
  input  logic            i_in_valid,
  input  logic [N-1:0]    i_in_a,
  input  logic [N-1:0]    i_in_b,
  output logic            o_in_ready,
  output logic [N-1:0]    o_mul_a,
  output logic [N-1:0]    o_mul_b,
  input  logic [PW-1:0]   i_mul_p,
  output logic            o_acc_valid,
  input  logic            i_acc_ready,
  output logic [ACCW-1:0] o_acc_out,
  output logic            o_busy,
  output logic            o_ovf
);

  state_t          r_state;
  logic [CNTW-1:0] r_len;
  logic [CNTW-1:0] r_cnt;
  logic            r_pend_nz;
  logic            r_pend_zero;
  logic            r_in_ready;
  logic            r_acc_valid;
  logic            r_busy;
  logic [N-1:0]    r_mul_a;
  logic [N-1:0]    r_mul_b;

  logic            w_xfer;
  logic            w_nz;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            w_last;
  logic            w_clr;
  logic            w_add_en;
  logic [PW-1:0]   w_addend;

  assign w_xfer    = r_in_ready & i_in_valid;
  assign w_nz      = (|i_in_a) & (|i_in_b);
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_last    = (w_cnt_nxt == r_len);

  // A start in IDLE wipes the previous sum and ovf, whatever the length
  assign w_clr = (r_state == ST_IDLE) & i_start;

  // The product seen now belongs to the beat accepted on the previous edge;
  // a zero beat still occupies an accumulate slot but adds nothing
  assign w_add_en = r_pend_nz | r_pend_zero;
  assign w_addend = r_pend_nz ? i_mul_p : '0;

  // Sequencer: burst acceptance, operand isolation and registered handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_pend_nz   <= 1'b0;
      r_pend_zero <= 1'b0;
      r_in_ready  <= 1'b0;
      r_acc_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            if (i_len != '0) begin
              r_len      <= i_len;
              r_cnt      <= '0;
              r_in_ready <= 1'b1;
              r_state    <= ST_RUN;
            end else begin
              r_acc_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_cnt       <= w_cnt_nxt;
            r_pend_nz   <= w_nz;
            r_pend_zero <= ~w_nz;
            // Zero-skip: leave the multiplier inputs still so it does not toggle
            if (w_nz) begin
              r_mul_a <= i_in_a;
              r_mul_b <= i_in_b;
            end
            if (w_last) begin
              r_in_ready <= 1'b0;
              r_state    <= ST_DRAIN;
            end
          end else begin
            r_pend_nz   <= 1'b0;
            r_pend_zero <= 1'b0;
          end
        end
        ST_DRAIN: begin
          r_pend_nz   <= 1'b0;
          r_pend_zero <= 1'b0;
          r_acc_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (r_acc_valid && i_acc_ready) begin
            r_acc_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  lpm_acc_unit #(
    .PW   (PW),
    .ACCW (ACCW)
  ) u_acc (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_clr),
    .i_add_en (w_add_en),
    .i_addend (w_addend),
    .o_acc    (o_acc_out),
    .o_ovf    (o_ovf)
  );

  assign o_in_ready  = r_in_ready;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_acc_valid = r_acc_valid;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_lpm_mac_ctrl.sv
// tb/tb_lpm_mac_ctrl.sv - scoreboard bench for the MAC sequencer (28-bit and 17-bit accumulators)
module tb_lpm_mac_ctrl;

  typedef struct {
    logic [27:0] acc;
    logic        ovf;
    logic [16:0] acc2;
    logic        ovf2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        acc_ready;

  logic        in_ready, acc_valid, busy, ovf;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] prod;
  logic [19:0] mul_p;
  logic [27:0] acc_out;

  logic        in_ready2, acc_valid2, busy2, ovf2;
  logic [7:0]  mul_a2, mul_b2;
  logic [15:0] prod2;
  logic [16:0] mul_p2;
  logic [16:0] acc_out2;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external multiplier
  assign prod   = mul_a * mul_b;
  assign mul_p  = {4'b0, prod};
  assign prod2  = mul_a2 * mul_b2;
  assign mul_p2 = {1'b0, prod2};

  lpm_mac_ctrl u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len),
    .i_in_valid(in_valid), .i_in_a(in_a), .i_in_b(in_b), .o_in_ready(in_ready),
    .o_mul_a(mul_a), .o_mul_b(mul_b), .i_mul_p(mul_p),
    .o_acc_valid(acc_valid), .i_acc_ready(acc_ready), .o_acc_out(acc_out),
    .o_busy(busy), .o_ovf(ovf)
  );

  lpm_mac_ctrl #(.PW(17), .ACCW(17)) u_dut17 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len),
    .i_in_valid(in_valid), .i_in_a(in_a), .i_in_b(in_b), .o_in_ready(in_ready2),
    .o_mul_a(mul_a2), .o_mul_b(mul_b2), .i_mul_p(mul_p2),
    .o_acc_valid(acc_valid2), .i_acc_ready(acc_ready), .o_acc_out(acc_out2),
    .o_busy(busy2), .o_ovf(ovf2)
  );

  function automatic exp_t mk_exp(input longint unsigned sum);
    exp_t e;
    e.acc  = sum[27:0];
    e.ovf  = (sum >> 28) != 0;
    e.acc2 = sum[16:0];
    e.ovf2 = (sum >> 17) != 0;
    return e;
  endfunction

  task automatic pulse_start(input logic [7:0] l);
    @(negedge clk); start = 1'b1; len = l;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, output bit ok);
    in_valid = 1'b1; in_a = a; in_b = b; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (acc_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; acc_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({in_ready, mul_a, mul_b, acc_valid, acc_out, busy, ovf} !== '0)
      $display("FAIL reset_outputs: got rdy=%b a=%0d b=%0d vld=%b acc=%0d busy=%b ovf=%b expected all 0",
               in_ready, mul_a, mul_b, acc_valid, acc_out, busy, ovf);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({busy, busy2, acc_valid2, acc_out2, ovf2} !== '0)
      $display("FAIL reset_release: got busy=%b busy17=%b vld17=%b acc17=%0d ovf17=%b expected all 0",
               busy, busy2, acc_valid2, acc_out2, ovf2);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    acc_ready = 1'b1;
    sb.push_back(mk_exp(3*4 + 255*255 + 0*77));
    pulse_start(8'd3);
    n_total++;
    if ({in_ready, busy} !== 2'b11)
      $display("FAIL b2b_run_entry: got rdy=%b busy=%b expected 1 1", in_ready, busy);
    else n_pass++;
    in_valid = 1'b1; in_a = 8'd3;   in_b = 8'd4;
    @(negedge clk);  in_a = 8'd255; in_b = 8'd255;
    @(negedge clk);  in_a = 8'd0;   in_b = 8'd77;
    @(negedge clk);  in_valid = 1'b0;
    n_total++;
    if ({mul_a, mul_b, in_ready, acc_valid} !== {8'd255, 8'd255, 1'b0, 1'b0})
      $display("FAIL b2b_zero_beat: got a=%0d b=%0d rdy=%b vld=%b expected 255 255 0 0",
               mul_a, mul_b, in_ready, acc_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (acc_valid !== 1'b1)
      $display("FAIL b2b_valid_latency: got vld=%b expected 1 two cycles after last accept", acc_valid);
    else n_pass++;
    e = sb.pop_front();
    n_total++;
    if ({acc_out, ovf, acc_out2, ovf2} !== {e.acc, e.ovf, e.acc2, e.ovf2})
      $display("FAIL b2b_result: got acc=%0d ovf=%b acc17=%0d ovf17=%b expected %0d %b %0d %b",
               acc_out, ovf, acc_out2, ovf2, e.acc, e.ovf, e.acc2, e.ovf2);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({acc_valid, busy, acc_out} !== {1'b0, 1'b0, e.acc})
      $display("FAIL b2b_return_idle: got vld=%b busy=%b acc=%0d expected 0 0 %0d",
               acc_valid, busy, acc_out, e.acc);
    else n_pass++;
  endtask

  task automatic test_len0();
    exp_t e;
    acc_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
    sb.push_back(mk_exp(0));
    pulse_start(8'd0);
    n_total++;
    if ({acc_valid, busy, in_ready, mul_a} !== {1'b1, 1'b1, 1'b0, 8'd255})
      $display("FAIL len0_done: got vld=%b busy=%b rdy=%b a=%0d expected 1 1 0 255",
               acc_valid, busy, in_ready, mul_a);
    else n_pass++;
    e = sb.pop_front();
    n_total++;
    if ({acc_out, ovf, acc_out2, ovf2} !== {e.acc, e.ovf, e.acc2, e.ovf2})
      $display("FAIL len0_result: got acc=%0d ovf=%b acc17=%0d ovf17=%b expected %0d %b %0d %b",
               acc_out, ovf, acc_out2, ovf2, e.acc, e.ovf, e.acc2, e.ovf2);
    else n_pass++;
    acc_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({acc_valid, busy} !== 2'b00)
      $display("FAIL len0_release: got vld=%b busy=%b expected 0 0", acc_valid, busy);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    exp_t e;
    bit   ok1, ok2, okv;
    acc_ready = 1'b0;
    sb.push_back(mk_exp(10*10 + 20*5));
    pulse_start(8'd2);
    send_beat(8'd10, 8'd10, ok1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    send_beat(8'd20, 8'd5, ok2);
    n_total++;
    if ({ok1, ok2} !== 2'b11)
      $display("FAIL bubbles_accept: got accepted=%b%b expected 11", ok1, ok2);
    else n_pass++;
    in_a = 8'd9; in_b = 8'd9;
    n_total++;
    if (in_ready !== 1'b0)
      $display("FAIL bubbles_ready_drop: got rdy=%b expected 0", in_ready);
    else n_pass++;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    n_total++;
    if ({mul_a, mul_b} !== {8'd20, 8'd5})
      $display("FAIL bubbles_no_extra: got a=%0d b=%0d expected 20 5", mul_a, mul_b);
    else n_pass++;
    wait_valid(okv);
    e = sb.pop_front();
    n_total++;
    if (!okv || {acc_out, ovf, acc_out2, ovf2} !== {e.acc, e.ovf, e.acc2, e.ovf2})
      $display("FAIL bubbles_result: got vld=%b acc=%0d ovf=%b acc17=%0d ovf17=%b expected 1 %0d %b %0d %b",
               okv, acc_out, ovf, acc_out2, ovf2, e.acc, e.ovf, e.acc2, e.ovf2);
    else n_pass++;
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
  endtask

  task automatic test_ovf();
    exp_t e;
    bit   ok;
    bit   all_ok = 1'b1;
    acc_ready = 1'b0;
    sb.push_back(mk_exp(3*255*255));
    pulse_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      send_beat(8'd255, 8'd255, ok);
      all_ok &= ok;
    end
    in_valid = 1'b0;
    wait_valid(ok);
    e = sb.pop_front();
    n_total++;
    if (!(all_ok && ok) || {acc_out, ovf, acc_out2, ovf2} !== {e.acc, e.ovf, e.acc2, e.ovf2})
      $display("FAIL ovf_result: got ok=%b acc=%0d ovf=%b acc17=%0d ovf17=%b expected 1 %0d %b %0d %b",
               all_ok && ok, acc_out, ovf, acc_out2, ovf2, e.acc, e.ovf, e.acc2, e.ovf2);
    else n_pass++;
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
  endtask

  task automatic test_done_hold();
    exp_t e;
    bit   ok;
    acc_ready = 1'b0;
    sb.push_back(mk_exp(6*7));
    pulse_start(8'd1);
    n_total++;
    if ({ovf2, busy2} !== 2'b01)
      $display("FAIL hold_ovf_clear: got ovf17=%b busy17=%b expected 0 1", ovf2, busy2);
    else n_pass++;
    send_beat(8'd6, 8'd7, ok);
    in_valid = 1'b0;
    wait_valid(ok);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (!ok || {acc_valid, acc_out} !== {1'b1, e.acc})
        $display("FAIL hold_cycle%0d: got vld=%b acc=%0d expected 1 %0d", i, acc_valid, acc_out, e.acc);
      else n_pass++;
      start = (i == 2); len = 8'd5;
      @(negedge clk);
    end
    start = 1'b0;
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    n_total++;
    if ({acc_valid, busy, acc_out} !== {1'b0, 1'b0, e.acc})
      $display("FAIL hold_release: got vld=%b busy=%b acc=%0d expected 0 0 %0d",
               acc_valid, busy, acc_out, e.acc);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({busy, in_ready} !== 2'b00)
      $display("FAIL hold_start_ignored: got busy=%b rdy=%b expected 0 0", busy, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_midburst();
    exp_t e;
    bit   ok;
    acc_ready = 1'b0;
    pulse_start(8'd4);
    send_beat(8'd1, 8'd2, ok);
    send_beat(8'd3, 8'd4, ok);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({in_ready, mul_a, mul_b, acc_valid, acc_out, busy, ovf,
         in_ready2, mul_a2, mul_b2, acc_valid2, acc_out2, busy2, ovf2} !== '0)
      $display("FAIL midreset_clear: got rdy=%b a=%0d b=%0d vld=%b acc=%0d busy=%b ovf=%b acc17=%0d expected all 0",
               in_ready, mul_a, mul_b, acc_valid, acc_out, busy, ovf, acc_out2);
    else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk_exp(7*9));
    pulse_start(8'd1);
    send_beat(8'd7, 8'd9, ok);
    in_valid = 1'b0;
    wait_valid(ok);
    e = sb.pop_front();
    n_total++;
    if (!ok || {acc_out, ovf, acc_out2, ovf2} !== {e.acc, e.ovf, e.acc2, e.ovf2})
      $display("FAIL midreset_new_burst: got vld=%b acc=%0d ovf=%b acc17=%0d ovf17=%b expected 1 %0d %b %0d %b",
               ok, acc_out, ovf, acc_out2, ovf2, e.acc, e.ovf, e.acc2, e.ovf2);
    else n_pass++;
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_len0();
    test_bubbles();
    test_ovf();
    test_done_hold();
    test_reset_midburst();
    n_total++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drained: got %0d entries left expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/lpm_mac_ctrl.md
Name: lpm_mac_ctrl

Overview:
- Sequencing and accumulation stage wrapped around the 8x8 decoder-based low-power multiplier (20-bit product).
- Accepts a burst of LEN operand pairs over a valid/ready handshake and registers the operands that drive the multiplier inputs.
- Consumes the combinational product one cycle later and accumulates it.
- Returns the final sum over a valid/ready result handshake.
- Low-power policy: multiplier operands toggle only on non-zero beats (operand isolation / zero-skip).

Parameters:
- N, 8, operand width.
- PW, 20, product width from the multiplier.
- ACCW, 28, accumulator width; must be >= PW.
- CNTW, 8, width of the burst length and beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a burst; sampled only in IDLE.
- len  in  CNTW  number of operand pairs in the burst; latched on start.
- in_valid  in  1  operand pair valid.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_ready  out  1  stage accepts an operand pair.
- mul_a  out  N  registered operand A to the multiplier.
- mul_b  out  N  registered operand B to the multiplier.
- mul_p  in  PW  combinational product from the multiplier.
- acc_valid  out  1  result valid.
- acc_ready  in  1  result consumer ready.
- acc_out  out  ACCW  accumulated sum.
- busy  out  1  high in any state other than IDLE.
- ovf  out  1  sticky accumulator carry-out for the current burst.

Behaviour:
- Reset (async assert, sync release): state=IDLE. Outputs in_ready, mul_a, mul_b, acc_valid, acc_out, busy, ovf, the beat counter, and the pending flags all reset to 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and len!=0: latch len, clear acc_out and ovf, go to RUN.
  - start=1 and len=0: clear acc_out and ovf, go directly to DONE. acc_valid rises the next cycle with value 0.
  - start outside IDLE is ignored.
- RUN:
  - in_ready=1. A beat transfers on in_valid & in_ready.
  - On a transfer where in_a!=0 and in_b!=0: load mul_a/mul_b and set pend_nz=1.
  - On a transfer where either operand is 0: mul_a/mul_b hold their previous values and pend_zero=1.
  - On a cycle with no transfer: pend flags clear and the registers hold.
- Accumulate (pipelined, overlaps the next accept):
  - On the edge after a transfer cycle, acc_out += zero-extended mul_p if pend_nz; += 0 if pend_zero.
  - Latency: beat accepted at edge t is included in acc_out at edge t+1.
- Counting: the beat counter increments per transfer. On the transfer that makes count==len, the next state is DRAIN and in_ready drops the following cycle. No extra beat is ever accepted.
- DRAIN: in_ready=0. Accumulates the last pending product for one cycle, then goes to DONE.
- DONE:
  - acc_valid=1 and acc_out is stable.
  - Holds until acc_valid & acc_ready, then goes to IDLE with acc_valid=0 on the next cycle.
  - acc_out retains its value in IDLE until the next start.
- Arithmetic: unsigned; wraps modulo 2^ACCW. Any carry-out sets ovf, which stays set until the next start.
  - With default widths ovf is unreachable (255 x 65025 < 2^24).
- busy=1 in RUN, DRAIN and DONE.
- in_valid bubbles in RUN are legal; the burst simply stretches.
- Reset mid-burst: immediate return to IDLE with all outputs 0. The partial sum is discarded.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - N, PW, ACCW, CNTW default constants;
  - the 2-bit state encoding.
- One natural sub-module: lpm_acc_unit, the ACCW-wide accumulator with clear, add-enable, zero-extend of PW, and sticky carry-out.
- The multiplier itself stays external and is connected at the next level.

Test Plan:
- len=3, beats (3,4), (255,255), (0,77) back-to-back, acc_ready=1 -> acc_out=65037, ovf=0. mul_a/mul_b remain 255/255 during the zero beat. acc_valid asserts 2 cycles after the third accept.
- len=0 start -> DONE the next cycle, acc_valid=1, acc_out=0, no beats accepted.
- len=2, beats (10,10) and (20,5) with 3 idle in_valid cycles between them -> acc_out=200. in_ready=0 after the second accept; a third offered beat is not taken.
- ACCW=17, len=3, three beats (255,255) -> acc_out=195075-131072=64003, ovf=1. ovf clears on the next start.
- DONE with acc_ready=0 for 5 cycles -> acc_valid and acc_out hold. Raising acc_ready -> IDLE next cycle, busy=0. A start pulsed during DONE is ignored.
- rst_n asserted after 2 of len=4 beats -> asynchronous clear of all outputs. A new burst len=1 with (7,9) gives acc_out=63.
